// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-port data memory between the pipeline MEM stage (core
// port) and a debug/loader port. One transaction is in flight at a time. The
// grant is round-robin when both ports ask in the same cycle, so neither side
// can starve the other. The very first tie after reset goes to the core.
//
// Transaction timing, counted from the first cycle a request is seen in IDLE
// (cycle 0):
//    cycle 1               : ISSUE, one-cycle wr or rd strobe
//    cycles 2..1+MEM_LAT   : WAIT (reads only)
//    cycle 2 / 2+MEM_LAT   : DONE, one-cycle ack to the owner (write / read)
//
// Parameters
//    DATA_W   data word width
//    ADDR_W   memory word-address width
//    MEM_LAT  memory read latency in cycles, 1..4
//
// Ports
//    clk, reset                   clock, asynchronous active-low reset
//    core_req/we/addr/wdata       core request
//    core_rdata, core_ack         core read data (held), completion pulse
//    core_stall                   core_req while the core has not been acked
//    dbg_req/we/addr/wdata        debug request
//    dbg_rdata, dbg_ack           debug read data (held), completion pulse
//    wr, rd, addr, wr_data        memory strobes, address, write data
//    rd_data                      memory read data
//    busy                         a transaction is in flight
//    owner                        owner of current/last grant (0 core, 1 dbg)
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_ack,
   output logic              core_stall,

   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,

   output logic              wr,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data,

   output logic              busy,
   output logic              owner
);

   // State encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // Counter value of the final WAIT cycle. MEM_LAT is expected in 1..4,
   // which always fits the 3-bit counter.
   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   logic [1:0] state;
   logic       we_q;
   logic       last_grant;
   logic [2:0] wait_cnt;
   logic       any_req;
   logic       grant_dbg;

   // Round-robin arbitration: a lone requester always wins; on a tie the
   // port that did not win last time gets the grant.
   assign any_req   = core_req | dbg_req;
   assign grant_dbg = dbg_req & (~core_req | ~last_grant);

   // Main state machine. A request is only looked at in IDLE, so anything
   // the requester does with its inputs after the grant is ignored until
   // the transaction completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               state <= we_q ? DONE : WAIT;
            end
            WAIT: begin
               if (wait_cnt == LAT_LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Request capture. The winning port's command is copied at grant time and
   // held for the whole transaction so the memory sees a stable address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q       <= 1'b0;
         addr       <= '0;
         wr_data    <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else if (state == IDLE && any_req) begin
         owner      <= grant_dbg;
         last_grant <= grant_dbg;
         if (grant_dbg) begin
            we_q    <= dbg_we;
            addr    <= dbg_addr;
            wr_data <= dbg_wdata;
         end else begin
            we_q    <= core_we;
            addr    <= core_addr;
            wr_data <= core_wdata;
         end
      end
   end

   // Read-latency counter. Cleared while the strobe is issued, then counts
   // the WAIT cycles until the memory data is due.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (state == ISSUE) begin
         wait_cnt <= '0;
      end else if (state == WAIT && wait_cnt != LAT_LAST) begin
         wait_cnt <= wait_cnt + 3'd1;
      end
   end

   // Read-data return. The memory word is captured on the edge that ends
   // the last WAIT cycle, into the owner's register only. Each register
   // holds until that port's next read completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_rdata <= '0;
         dbg_rdata  <= '0;
      end else if (state == WAIT && wait_cnt == LAT_LAST) begin
         if (owner) begin
            dbg_rdata <= rd_data;
         end else begin
            core_rdata <= rd_data;
         end
      end
   end

   // Strobes, acks and status are decoded straight from the state register,
   // so an asynchronous reset drops them in the same instant it hits.
   always_comb begin
      wr         = 1'b0;
      rd         = 1'b0;
      core_ack   = 1'b0;
      dbg_ack    = 1'b0;
      if (state == ISSUE) begin
         wr = we_q;
         rd = ~we_q;
      end
      if (state == DONE) begin
         core_ack = ~owner;
         dbg_ack  = owner;
      end
   end

   assign busy = (state != IDLE);

   // The stall is combinational so the pipeline is released in the same
   // cycle as its ack, and stays stalled while debug owns the memory.
   assign core_stall = core_req & ~core_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter. Two instances are exercised: one
// with a one-cycle memory and one with a four-cycle memory. Each has its own
// behavioural memory whose read pipeline returns filler data when no read is
// due, so a sample taken on the wrong cycle is visible. Expected transaction
// results are queued when a request is driven and popped when the ack shows.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 9;

   typedef struct {
      int          d;
      bit          port;
      bit          we;
      logic [31:0] rdata;
      int          ack_cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          dut_reset  [2];
   logic          core_req   [2];
   logic          core_we    [2];
   logic [AW-1:0] core_addr  [2];
   logic [DW-1:0] core_wdata [2];
   logic [DW-1:0] core_rdata [2];
   logic          core_ack   [2];
   logic          core_stall [2];
   logic          dbg_req    [2];
   logic          dbg_we     [2];
   logic [AW-1:0] dbg_addr   [2];
   logic [DW-1:0] dbg_wdata  [2];
   logic [DW-1:0] dbg_rdata  [2];
   logic          dbg_ack    [2];
   logic          wr         [2];
   logic          rd         [2];
   logic [AW-1:0] addr       [2];
   logic [DW-1:0] wr_data    [2];
   logic [DW-1:0] rd_data    [2];
   logic          busy       [2];
   logic          owner      [2];

   logic          bd_we      [2];
   logic [AW-1:0] bd_addr    [2];
   logic [DW-1:0] bd_data    [2];

   logic [DW-1:0] mem   [2][512];
   logic [DW-1:0] stage [2][4];

   logic [DW-1:0] model_core [2];
   logic [DW-1:0] model_dbg  [2];

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) dut_lat1 (
      .clk(clk), .reset(dut_reset[0]),
      .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
      .core_wdata(core_wdata[0]), .core_rdata(core_rdata[0]),
      .core_ack(core_ack[0]), .core_stall(core_stall[0]),
      .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]),
      .dbg_wdata(dbg_wdata[0]), .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
      .wr(wr[0]), .rd(rd[0]), .addr(addr[0]), .wr_data(wr_data[0]),
      .rd_data(rd_data[0]), .busy(busy[0]), .owner(owner[0])
   );

   data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(4)) dut_lat4 (
      .clk(clk), .reset(dut_reset[1]),
      .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
      .core_wdata(core_wdata[1]), .core_rdata(core_rdata[1]),
      .core_ack(core_ack[1]), .core_stall(core_stall[1]),
      .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]),
      .dbg_wdata(dbg_wdata[1]), .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
      .wr(wr[1]), .rd(rd[1]), .addr(addr[1]), .wr_data(wr_data[1]),
      .rd_data(rd_data[1]), .busy(busy[1]), .owner(owner[1])
   );

   // Behavioural memories: index 0 answers one cycle after rd, index 1
   // four cycles after rd. Filler data fills the pipeline otherwise.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (wr[i] === 1'b1) mem[i][addr[i]] <= wr_data[i];
         if (bd_we[i] === 1'b1) mem[i][bd_addr[i]] <= bd_data[i];
         stage[i][0] <= (rd[i] === 1'b1) ? mem[i][addr[i]] : 32'hBADBAD00;
         for (int j = 1; j < 4; j++) stage[i][j] <= stage[i][j-1];
      end
   end

   assign rd_data[0] = stage[0][0];
   assign rd_data[1] = stage[1][3];

   // Single comparison point: counts, and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_port(input int d, input bit port, input bit req, input bit we,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (!port) begin
         core_req[d] = req; core_we[d] = we; core_addr[d] = a; core_wdata[d] = wd;
      end else begin
         dbg_req[d] = req; dbg_we[d] = we; dbg_addr[d] = a; dbg_wdata[d] = wd;
      end
   endtask

   // Drives a new request and records the result it must produce.
   task automatic applyStimulus(input int d, input bit port, input bit we, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int ack_c);
      exp_t item;
      drive_port(d, port, 1'b1, we, a, wd);
      item.d = d; item.port = port; item.we = we; item.rdata = exp_rd; item.ack_cyc = ack_c;
      sb.push_back(item);
   endtask

   task automatic backdoor(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
      @(posedge clk); #1;
      bd_we[d] = 1'b1; bd_addr[d] = a; bd_data[d] = v;
      @(posedge clk); #1;
      bd_we[d] = 1'b0;
   endtask

   task automatic check_reset_state(input int d);
      string id;
      id = $sformatf("rst d%0d", d);
      checkOutput({id, " wr"}, 32'(wr[d]), 32'd0);
      checkOutput({id, " rd"}, 32'(rd[d]), 32'd0);
      checkOutput({id, " core_ack"}, 32'(core_ack[d]), 32'd0);
      checkOutput({id, " dbg_ack"}, 32'(dbg_ack[d]), 32'd0);
      checkOutput({id, " busy"}, 32'(busy[d]), 32'd0);
      checkOutput({id, " owner"}, 32'(owner[d]), 32'd0);
      checkOutput({id, " addr"}, 32'(addr[d]), 32'd0);
      checkOutput({id, " wr_data"}, wr_data[d], 32'd0);
      checkOutput({id, " core_rdata"}, core_rdata[d], model_core[d]);
      checkOutput({id, " dbg_rdata"}, dbg_rdata[d], model_dbg[d]);
   endtask

   // One complete transaction on one port with a cycle-by-cycle check.
   // The requester scrambles its inputs after the grant and drops req the
   // cycle after its ack.
   task automatic run_txn(input int d, input bit port, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
      int    lat;
      int    ack_c;
      logic  obs_ack;
      exp_t  item;
      string id;
      lat   = (d == 0) ? 1 : 4;
      ack_c = we ? 2 : 2 + lat;
      for (int c = 0; c <= ack_c + 1; c++) begin
         @(posedge clk); #1;
         if (c == 0) applyStimulus(d, port, we, a, wd, exp_rd, ack_c);
         else if (c <= ack_c) drive_port(d, port, 1'b1, ~we, ~a, ~wd);
         else drive_port(d, port, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
         id = $sformatf("d%0d p%0d we%0d c%0d", d, port, we, c);
         if (c == ack_c && !we) begin
            if (port) model_dbg[d] = exp_rd;
            else model_core[d] = exp_rd;
         end
         checkOutput({id, " wr"}, 32'(wr[d]), 32'((c == 1) && we));
         checkOutput({id, " rd"}, 32'(rd[d]), 32'((c == 1) && !we));
         checkOutput({id, " core_ack"}, 32'(core_ack[d]), 32'((c == ack_c) && !port));
         checkOutput({id, " dbg_ack"}, 32'(dbg_ack[d]), 32'((c == ack_c) && port));
         checkOutput({id, " busy"}, 32'(busy[d]), 32'((c >= 1) && (c <= ack_c)));
         checkOutput({id, " core_stall"}, 32'(core_stall[d]), 32'(!port && (c < ack_c)));
         checkOutput({id, " core_rdata"}, core_rdata[d], model_core[d]);
         checkOutput({id, " dbg_rdata"}, dbg_rdata[d], model_dbg[d]);
         if (c >= 1) checkOutput({id, " owner"}, 32'(owner[d]), 32'(port));
         if (c >= 1 && c <= ack_c) begin
            checkOutput({id, " addr"}, 32'(a), 32'(addr[d]));
            if (we) checkOutput({id, " wr_data"}, wr_data[d], wd);
         end
         obs_ack = port ? dbg_ack[d] : core_ack[d];
         if (obs_ack === 1'b1) begin
            checkOutput({id, " ack_pending"}, 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
               item = sb.pop_front();
               checkOutput({id, " ack_cycle"}, 32'(c), 32'(item.ack_cyc));
               if (!item.we) begin
                  checkOutput({id, " ack_rdata"}, port ? dbg_rdata[d] : core_rdata[d], item.rdata);
               end
            end
         end
      end
      checkOutput($sformatf("d%0d ack_seen", d), 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rv;
      bit            rp;
      string         id;

      for (int i = 0; i < 2; i++) begin
         dut_reset[i] = 1'b0;
         drive_port(i, 1'b0, 1'b0, 1'b0, '0, '0);
         drive_port(i, 1'b1, 1'b0, 1'b0, '0, '0);
         bd_we[i] = 1'b0; bd_addr[i] = '0; bd_data[i] = '0;
         model_core[i] = '0; model_dbg[i] = '0;
      end

      // Power-on reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state(0);
      check_reset_state(1);
      @(posedge clk); #1;
      dut_reset[0] = 1'b1;
      dut_reset[1] = 1'b1;

      // Core read through the one-cycle memory
      backdoor(0, 9'h010, 32'hDEADBEEF);
      run_txn(0, 1'b0, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF);

      // Debug write to the top address, then read it back
      run_txn(0, 1'b1, 1'b1, 9'h1FF, 32'hA5A5A5A5, 32'h0);
      run_txn(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 32'hA5A5A5A5);

      // Core write and read-back
      run_txn(0, 1'b0, 1'b1, 9'h0AA, 32'h0F0F0F0F, 32'h0);
      run_txn(0, 1'b0, 1'b0, 9'h0AA, 32'h0, 32'h0F0F0F0F);

      // Debug read through the four-cycle memory
      backdoor(1, 9'h100, 32'hCAFEF00D);
      run_txn(1, 1'b1, 1'b0, 9'h100, 32'h0, 32'hCAFEF00D);

      // A few random write/read-back pairs on both instances
      for (int i = 0; i < 4; i++) begin
         ra = AW'($urandom_range(0, 511));
         rv = $urandom;
         rp = 1'($urandom_range(0, 1));
         run_txn(i % 2, rp, 1'b1, ra, rv, 32'h0);
         run_txn(i % 2, ~rp, 1'b0, ra, 32'h0, rv);
      end

      // Both ports writing continuously from reset release: grants alternate
      @(posedge clk); #1;
      dut_reset[0] = 1'b0;
      model_core[0] = '0;
      model_dbg[0] = '0;
      drive_port(0, 1'b0, 1'b1, 1'b1, 9'h020, 32'h11111111);
      drive_port(0, 1'b1, 1'b1, 1'b1, 9'h021, 32'h22222222);
      for (int c = 0; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 0) dut_reset[0] = 1'b1;
         if (c == 12) begin
            drive_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
            drive_port(0, 1'b1, 1'b0, 1'b0, '0, '0);
         end
         @(negedge clk);
         id = $sformatf("rr c%0d", c);
         checkOutput({id, " core_ack"}, 32'(core_ack[0]), 32'(c == 2 || c == 8));
         checkOutput({id, " dbg_ack"}, 32'(dbg_ack[0]), 32'(c == 5 || c == 11));
         checkOutput({id, " core_stall"}, 32'(core_stall[0]), 32'(c < 12 && !(c == 2 || c == 8)));
         checkOutput({id, " wr"}, 32'(wr[0]), 32'(c >= 1 && c <= 10 && c % 3 == 1));
         checkOutput({id, " rd"}, 32'(rd[0]), 32'd0);
         if (c >= 1 && c <= 11) checkOutput({id, " owner"}, 32'(owner[0]), 32'(((c - 1) / 3) % 2));
         if (c >= 1 && c <= 10 && c % 3 == 1)
            checkOutput({id, " addr"}, 32'(addr[0]), ((c / 3) % 2 == 0) ? 32'h020 : 32'h021);
      end
      run_txn(0, 1'b1, 1'b0, 9'h021, 32'h0, 32'h22222222);
      run_txn(0, 1'b0, 1'b0, 9'h020, 32'h0, 32'h11111111);

      // Reset while a core read is waiting on the four-cycle memory
      backdoor(1, 9'h055, 32'h12345678);
      @(posedge clk); #1;
      drive_port(1, 1'b0, 1'b1, 1'b0, 9'h055, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rstwait issue rd", 32'(rd[1]), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rstwait wait busy", 32'(busy[1]), 32'd1);
      checkOutput("rstwait wait rd", 32'(rd[1]), 32'd0);
      @(posedge clk); #1;
      drive_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      dut_reset[1] = 1'b0;
      model_core[1] = '0;
      model_dbg[1] = '0;
      #1;
      check_reset_state(1);
      @(posedge clk); #1;
      dut_reset[1] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         id = $sformatf("post_rst c%0d", c);
         checkOutput({id, " core_ack"}, 32'(core_ack[1]), 32'd0);
         checkOutput({id, " dbg_ack"}, 32'(dbg_ack[1]), 32'd0);
         checkOutput({id, " busy"}, 32'(busy[1]), 32'd0);
         @(posedge clk);
      end
      run_txn(1, 1'b0, 1'b1, 9'h066, 32'h600DF00D, 32'h0);
      run_txn(1, 1'b0, 1'b0, 9'h066, 32'h0, 32'h600DF00D);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter ADDR_W, default 9, memory word-address width.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 core_req, core_we, core_addr, core_wdata  input  1/1/ADDR_W/DATA_W  pipeline MEM-stage request, write-enable, address, write data.
REQ-007 core_rdata, core_ack, core_stall  output  DATA_W/1/1  read data, completion pulse, pipeline stall.
REQ-008 dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_W/DATA_W  debug/loader request port.
REQ-009 dbg_rdata, dbg_ack  output  DATA_W/1  debug read data, completion pulse.
REQ-010 wr, rd, addr, wr_data  output  1/1/ADDR_W/DATA_W  data-memory write strobe, read strobe, address, write data.
REQ-011 rd_data  input  DATA_W  data-memory read data.
REQ-012 busy, owner  output  1/1  transaction in flight; owner of the current or last grant (0 = core, 1 = dbg).

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-014 IDLE: no request -> stay; any request -> latch requester's we/addr/wdata, set owner, go ISSUE.
REQ-015 Both requests in IDLE -> grant the requester not granted last (round-robin); single request -> grant it.
REQ-016 ISSUE: assert exactly one of wr/rd for one cycle with latched addr/wr_data; write -> DONE, read -> WAIT.
REQ-017 WAIT: hold MEM_LAT cycles (3-bit counter); rd_data sampled on the edge ending the last WAIT cycle into the owner's rdata register; -> DONE.
REQ-018 DONE: pulse owner's ack for exactly one cycle; -> IDLE.
REQ-019 Latency from first cycle req sampled high in IDLE (cycle 0): write ack in cycle 2; read ack in cycle 2+MEM_LAT.
REQ-020 wr and rd SHALL never be high simultaneously; both low outside ISSUE; addr/wr_data hold latched values in ISSUE, WAIT and DONE.
REQ-021 Requester holds req high until ack; req still high in the cycle after ack = new request (back-to-back legal).
REQ-022 Request inputs changing after the grant SHALL not affect the in-flight transaction.
REQ-023 core_rdata/dbg_rdata update only on that port's read completion; held otherwise; writes do not alter them.
REQ-024 core_stall = core_req AND NOT core_ack (combinational), so the pipeline stalls through debug-owned transactions.
REQ-025 busy high in ISSUE, WAIT, DONE; low in IDLE.
REQ-026 Non-owner ack SHALL stay low for the whole transaction.

Reset
REQ-027 reset low SHALL immediately force IDLE, wr=0, rd=0, core_ack=0, dbg_ack=0, busy=0, addr=0, wr_data=0.
REQ-028 Reset SHALL clear core_rdata, dbg_rdata and counter to 0, and set last-grant to dbg so core wins first tie; owner=0.
REQ-029 Reset mid-transaction SHALL discard it with no ack; first request after release starts from cycle 0.

Verification
REQ-030 MEM_LAT=1, core read addr 9'h010, memory holds 32'hDEADBEEF -> rd high cycle 1, core_ack and core_rdata=32'hDEADBEEF cycle 3, core_stall high cycles 0-2.
REQ-031 dbg write addr 9'h1FF data 32'hA5A5A5A5 -> wr high cycle 1 only, dbg_ack cycle 2, core_ack never high, core_rdata unchanged.
REQ-032 Both req high continuously from reset release, all writes -> grants alternate core, dbg, core, dbg; each ack 3 cycles apart.
REQ-033 MEM_LAT=4, dbg read -> rd cycle 1, dbg_ack cycle 6; changing dbg_addr in cycle 2 leaves addr stable.
REQ-034 reset low during WAIT -> wr/rd/ack low immediately; no ack after release; next core write acks in cycle 2.
